// File: rtl/motor_pwm_ctrl.sv
// motor_pwm_ctrl: multi-channel H-bridge driver with PWM speed,
// linear duty ramp, reversal dead-time and active brake.
module motor_pwm_ctrl #(
  parameter int NUM_CH    = 2,
  parameter int PWM_BITS  = 8,
  parameter int DEADTIME  = 16,
  parameter int RAMP_STEP = 4,
  localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [CHW-1:0]      cmd_ch,
  input  logic [1:0]          cmd_mode,
  input  logic [PWM_BITS-1:0] cmd_duty,
  output logic [NUM_CH-1:0]   en,
  output logic [NUM_CH-1:0]   in_a,
  output logic [NUM_CH-1:0]   in_b,
  output logic [NUM_CH-1:0]   fb,
  output logic [NUM_CH-1:0]   busy
);

  localparam int DW = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;
  localparam logic [DW-1:0] DT_LOAD = DW'(DEADTIME - 1);
  localparam logic [PWM_BITS-1:0] WRAP =
    {{(PWM_BITS-1){1'b1}}, 1'b0};
  localparam logic [PWM_BITS-1:0] STEP = PWM_BITS'(RAMP_STEP);

  typedef enum logic [2:0] {
    COAST, RUN_F, RUN_R, DEAD, BRAKE
  } st_t;

  st_t                 state_q [NUM_CH];
  st_t                 state_d [NUM_CH];
  logic [PWM_BITS-1:0] cur_q   [NUM_CH];
  logic [PWM_BITS-1:0] cur_d   [NUM_CH];
  logic [PWM_BITS-1:0] tgt_q   [NUM_CH];
  logic [PWM_BITS-1:0] tgt_d   [NUM_CH];
  logic [DW-1:0]       dcnt_q  [NUM_CH];
  logic [DW-1:0]       dcnt_d  [NUM_CH];
  logic [NUM_CH-1:0]   dir_q;
  logic [NUM_CH-1:0]   dir_d;
  logic [PWM_BITS-1:0] cnt_q;
  logic [NUM_CH-1:0]   pwm;
  logic [NUM_CH-1:0]   en_d;
  logic [NUM_CH-1:0]   a_d;
  logic [NUM_CH-1:0]   b_d;
  logic [NUM_CH-1:0]   busy_d;
  logic                wrap;
  logic                take;
  logic                ndir;

  assign wrap = (cnt_q == WRAP);
  assign take = cmd_valid && cmd_ready;
  assign ndir = cmd_mode[1];

  // Ready is simply "out of reset", one edge after release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cmd_ready <= 1'b0;
    else     cmd_ready <= 1'b1;
  end

  // Shared PWM period counter, 0 .. 2^PWM_BITS-2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       cnt_q <= '0;
    else if (wrap) cnt_q <= '0;
    else           cnt_q <= cnt_q + 1'b1;
  end

  // Per-channel state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dir_q <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= COAST;
        cur_q[i]   <= '0;
        tgt_q[i]   <= '0;
        dcnt_q[i]  <= '0;
      end
    end else begin
      dir_q <= dir_d;
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= state_d[i];
        cur_q[i]   <= cur_d[i];
        tgt_q[i]   <= tgt_d[i];
        dcnt_q[i]  <= dcnt_d[i];
      end
    end
  end

  // Next state: a command for the channel beats ramp/dead-time.
  always_comb begin
    dir_d = dir_q;
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i] = state_q[i];
      cur_d[i]   = cur_q[i];
      tgt_d[i]   = tgt_q[i];
      dcnt_d[i]  = dcnt_q[i];
      if (take && int'(cmd_ch) == i) begin
        tgt_d[i] = cmd_duty;
        unique case (cmd_mode)
          2'b00: begin
            state_d[i] = COAST;
            cur_d[i]   = '0;
          end
          2'b11: begin
            state_d[i] = BRAKE;
            cur_d[i]   = '0;
          end
          default: begin
            unique case (state_q[i])
              RUN_F, RUN_R: begin
                if (ndir != dir_q[i]) begin
                  state_d[i] = DEAD;
                  dir_d[i]   = ndir;
                  dcnt_d[i]  = DT_LOAD;
                  cur_d[i]   = '0;
                end
              end
              DEAD: begin
                if (ndir != dir_q[i]) begin
                  dir_d[i]  = ndir;
                  dcnt_d[i] = DT_LOAD;
                end
              end
              default: begin
                state_d[i] = ndir ? RUN_R : RUN_F;
                dir_d[i]   = ndir;
              end
            endcase
          end
        endcase
      end else begin
        unique case (state_q[i])
          DEAD: begin
            if (dcnt_q[i] == '0) begin
              state_d[i] = dir_q[i] ? RUN_R : RUN_F;
              cur_d[i]   = '0;
            end else begin
              dcnt_d[i] = dcnt_q[i] - 1'b1;
            end
          end
          RUN_F, RUN_R: begin
            if (wrap) begin
              unique case (1'b1)
                (cur_q[i] < tgt_q[i]):
                  cur_d[i] = (tgt_q[i] - cur_q[i] > STEP)
                           ? cur_q[i] + STEP : tgt_q[i];
                (cur_q[i] > tgt_q[i]):
                  cur_d[i] = (cur_q[i] - tgt_q[i] > STEP)
                           ? cur_q[i] - STEP : tgt_q[i];
                default: ;
              endcase
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Bridge pin decode from current state and PWM compare.
  always_comb begin
    pwm    = '0;
    en_d   = '0;
    a_d    = '0;
    b_d    = '0;
    busy_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      pwm[i] = (cur_q[i] > cnt_q);
      unique case (state_q[i])
        RUN_F: begin
          en_d[i] = pwm[i];
          a_d[i]  = 1'b1;
        end
        RUN_R: begin
          en_d[i] = pwm[i];
          b_d[i]  = 1'b1;
        end
        BRAKE: begin
          en_d[i] = 1'b1;
          a_d[i]  = 1'b1;
          b_d[i]  = 1'b1;
        end
        default: ;
      endcase
      busy_d[i] = (state_q[i] == DEAD) ||
                  (((state_q[i] == RUN_F) ||
                    (state_q[i] == RUN_R)) &&
                   (cur_q[i] != tgt_q[i]));
    end
  end

  // Registered outputs; reset clears them without waiting for clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en   <= '0;
      in_a <= '0;
      in_b <= '0;
      fb   <= '0;
      busy <= '0;
    end else begin
      en   <= en_d;
      in_a <= a_d;
      in_b <= b_d;
      fb   <= dir_q;
      busy <= busy_d;
    end
  end

endmodule

// File: tb/tb_motor_pwm_ctrl.sv
// tb_motor_pwm_ctrl: directed bench for motor_pwm_ctrl.
// Three channels so an out-of-range channel index is expressible.
module tb_motor_pwm_ctrl;

  localparam int PER = 255;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_ch = '0;
  logic [1:0] cmd_mode = '0;
  logic [7:0] cmd_duty = '0;
  logic [2:0] en, in_a, in_b, fb, busy;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  motor_pwm_ctrl #(
    .NUM_CH(3), .PWM_BITS(8), .DEADTIME(16), .RAMP_STEP(4)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ch(cmd_ch), .cmd_mode(cmd_mode), .cmd_duty(cmd_duty),
    .en(en), .in_a(in_a), .in_b(in_b), .fb(fb), .busy(busy)
  );

  task automatic send_cmd(input logic [1:0] ch,
                          input logic [1:0] mode,
                          input logic [7:0] duty);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_ch    = ch;
    cmd_mode  = mode;
    cmd_duty  = duty;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic count_en(input int ch, output int n);
    n = 0;
    repeat (PER) begin
      @(negedge clk);
      if (en[ch]) n++;
    end
  endtask

  task automatic test_reset;
    #1;
    checks++;
    if ({en, in_a, in_b, fb, busy} !== 15'h0) begin
      failures++;
      $display("FAIL reset_outs got=%h exp=0",
               {en, in_a, in_b, fb, busy});
    end
    checks++;
    if (cmd_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_ready got=%b exp=0", cmd_ready);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (cmd_ready !== 1'b0) begin
      failures++;
      $display("FAIL ready_pre_edge got=%b exp=0", cmd_ready);
    end
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL ready_post_edge got=%b exp=1", cmd_ready);
    end
  endtask

  task automatic test_forward;
    int n;
    send_cmd(2'd0, 2'b01, 8'h80);
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({in_a[0], in_b[0], fb[0], busy[0]} !== 4'b1001) begin
      failures++;
      $display("FAIL fwd_pins got=%b exp=1001",
               {in_a[0], in_b[0], fb[0], busy[0]});
    end
    repeat (33 * PER) @(negedge clk);
    checks++;
    if (busy[0] !== 1'b0) begin
      failures++;
      $display("FAIL fwd_ramp_done got=%b exp=0", busy[0]);
    end
    count_en(0, n);
    checks++;
    if (n != 128) begin
      failures++;
      $display("FAIL fwd_duty80 got=%0d exp=128", n);
    end
  endtask

  task automatic test_reversal;
    int n;
    int zeros;
    int first_b;
    int overlap;
    send_cmd(2'd0, 2'b01, 8'h40);
    repeat (17 * PER) @(negedge clk);
    count_en(0, n);
    checks++;
    if (n != 64 || busy[0] !== 1'b0) begin
      failures++;
      $display("FAIL ramp_down40 got=%0d/%b exp=64/0", n, busy[0]);
    end
    send_cmd(2'd0, 2'b10, 8'h40);
    zeros = 0;
    first_b = -1;
    overlap = 0;
    for (int s = 0; s < 30; s++) begin
      @(negedge clk);
      if ({en[0], in_a[0], in_b[0]} == 3'b000) zeros++;
      if (in_b[0] && first_b < 0) first_b = s;
      if (in_a[0] && in_b[0]) overlap++;
      if (s == 8) begin
        checks++;
        if ({fb[0], busy[0]} !== 2'b11) begin
          failures++;
          $display("FAIL dead_fb_busy got=%b exp=11",
                   {fb[0], busy[0]});
        end
      end
    end
    checks++;
    if (zeros != 16) begin
      failures++;
      $display("FAIL dead_len got=%0d exp=16", zeros);
    end
    checks++;
    if (first_b != 17 || overlap != 0) begin
      failures++;
      $display("FAIL rev_start got=%0d/%0d exp=17/0",
               first_b, overlap);
    end
    repeat (17 * PER) @(negedge clk);
    count_en(0, n);
    checks++;
    if (n != 64 || in_a[0] !== 1'b0 || busy[0] !== 1'b0) begin
      failures++;
      $display("FAIL rev_duty40 got=%0d/%b/%b exp=64/0/0",
               n, in_a[0], busy[0]);
    end
  endtask

  task automatic test_brake_coast;
    send_cmd(2'd1, 2'b11, 8'h00);
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({en[1], in_a[1], in_b[1]} !== 3'b111) begin
      failures++;
      $display("FAIL brake got=%b exp=111",
               {en[1], in_a[1], in_b[1]});
    end
    checks++;
    if ({in_a[0], in_b[0], fb[0]} !== 3'b011) begin
      failures++;
      $display("FAIL brake_ch0 got=%b exp=011",
               {in_a[0], in_b[0], fb[0]});
    end
    send_cmd(2'd1, 2'b00, 8'h00);
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({en[1], in_a[1], in_b[1], busy[1]} !== 4'b0000) begin
      failures++;
      $display("FAIL coast got=%b exp=0000",
               {en[1], in_a[1], in_b[1], busy[1]});
    end
    checks++;
    if ({in_a[0], in_b[0], busy[0]} !== 3'b010) begin
      failures++;
      $display("FAIL coast_ch0 got=%b exp=010",
               {in_a[0], in_b[0], busy[0]});
    end
  endtask

  task automatic test_restart;
    int zeros;
    bit run;
    send_cmd(2'd1, 2'b01, 8'h10);
    send_cmd(2'd1, 2'b10, 8'h10);
    repeat (10) @(posedge clk);
    send_cmd(2'd1, 2'b01, 8'h10);
    zeros = 0;
    run = 1'b1;
    for (int s = 0; s < 25; s++) begin
      @(negedge clk);
      if (run && {en[1], in_a[1], in_b[1]} == 3'b000) zeros++;
      else run = 1'b0;
      if (s == 2) begin
        checks++;
        if ({fb[1], busy[1]} !== 2'b01) begin
          failures++;
          $display("FAIL restart_fb got=%b exp=01",
                   {fb[1], busy[1]});
        end
      end
    end
    checks++;
    if (zeros != 17) begin
      failures++;
      $display("FAIL restart_len got=%0d exp=17", zeros);
    end
    checks++;
    if ({in_a[1], in_b[1]} !== 2'b10) begin
      failures++;
      $display("FAIL restart_dir got=%b exp=10",
               {in_a[1], in_b[1]});
    end
    send_cmd(2'd1, 2'b00, 8'h00);
  endtask

  task automatic test_boundaries;
    int n;
    send_cmd(2'd2, 2'b01, 8'hFE);
    repeat (65 * PER) @(negedge clk);
    count_en(2, n);
    checks++;
    if (n != 254 || busy[2] !== 1'b0) begin
      failures++;
      $display("FAIL duty_fe got=%0d/%b exp=254/0", n, busy[2]);
    end
    send_cmd(2'd2, 2'b01, 8'hFC);
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (busy[2] !== 1'b1) begin
      failures++;
      $display("FAIL fc_busy got=%b exp=1", busy[2]);
    end
    repeat (260) @(negedge clk);
    count_en(2, n);
    checks++;
    if (n != 252 || busy[2] !== 1'b0) begin
      failures++;
      $display("FAIL duty_fc got=%0d/%b exp=252/0", n, busy[2]);
    end
    send_cmd(2'd2, 2'b01, 8'hFF);
    repeat (260) @(negedge clk);
    count_en(2, n);
    checks++;
    if (n != 255 || busy[2] !== 1'b0) begin
      failures++;
      $display("FAIL duty_ff got=%0d/%b exp=255/0", n, busy[2]);
    end
    send_cmd(2'd1, 2'b01, 8'h00);
    repeat (3) @(negedge clk);
    count_en(1, n);
    checks++;
    if (n != 0 || in_a[1] !== 1'b1 || busy[1] !== 1'b0) begin
      failures++;
      $display("FAIL duty_00 got=%0d/%b/%b exp=0/1/0",
               n, in_a[1], busy[1]);
    end
  endtask

  task automatic test_bad_ch;
    send_cmd(2'd3, 2'b11, 8'h00);
    repeat (3) @(negedge clk);
    checks++;
    if ({in_a, in_b, fb, busy} !== {3'b110, 3'b001, 3'b001, 3'b000}) begin
      failures++;
      $display("FAIL bad_ch got=%b_%b_%b_%b exp=110_001_001_000",
               in_a, in_b, fb, busy);
    end
    checks++;
    if (en[2:1] !== 2'b10) begin
      failures++;
      $display("FAIL bad_ch_en got=%b exp=10", en[2:1]);
    end
  endtask

  task automatic test_reset_mid;
    send_cmd(2'd0, 2'b01, 8'h40);
    send_cmd(2'd2, 2'b01, 8'h10);
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 3'b101) begin
      failures++;
      $display("FAIL pre_rst_busy got=%b exp=101", busy);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({en, in_a, in_b, fb, busy} !== 15'h0 || cmd_ready !== 1'b0) begin
      failures++;
      $display("FAIL async_rst got=%h/%b exp=0/0",
               {en, in_a, in_b, fb, busy}, cmd_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({en, in_a, in_b, fb, busy} !== 15'h0 || cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL post_rst got=%h/%b exp=0/1",
               {en, in_a, in_b, fb, busy}, cmd_ready);
    end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_reversal();
    test_brake_coast();
    test_restart();
    test_boundaries();
    test_bad_ch();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
